// File: rtl/verify_ram.sv
// Read-back checker: bursts through a filled RAM bank over AXI4 reads and
// counts beats whose bytes differ from the fill constant.
module verify_ram #(
  parameter int          DW              = 512,
  parameter logic [7:0]  FILL_VALUE      = 8'hFC,
  parameter logic [63:0] BASE_ADDR       = 64'h0,
  parameter int          BLOCK_BYTES     = 4096,
  parameter int          BLOCK_COUNT     = 1024,
  parameter int          MAX_OUTSTANDING = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_async,
  output logic          idle,
  output logic [63:0]   elapsed,
  output logic [63:0]   error_count,
  output logic          first_err_valid,
  output logic [63:0]   first_err_addr,
  output logic [31:0]   resp_err_count,
  output logic [63:0]   M_AXI_ARADDR,
  output logic [7:0]    M_AXI_ARLEN,
  output logic [2:0]    M_AXI_ARSIZE,
  output logic [1:0]    M_AXI_ARBURST,
  output logic [3:0]    M_AXI_ARID,
  output logic          M_AXI_ARLOCK,
  output logic [3:0]    M_AXI_ARCACHE,
  output logic [2:0]    M_AXI_ARPROT,
  output logic [3:0]    M_AXI_ARQOS,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  input  logic [DW-1:0] M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RLAST,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);

  localparam int          BEAT_BYTES      = DW / 8;
  localparam int          BEAT_SHIFT      = $clog2(BEAT_BYTES);
  localparam int          BEATS_PER_BURST = BLOCK_BYTES / BEAT_BYTES;
  localparam logic [63:0] TOTAL_BEATS     = 64'(BLOCK_COUNT) * 64'(BEATS_PER_BURST);
  localparam logic [31:0] LAST_BEAT       = 32'(TOTAL_BEATS - 64'd1);
  localparam logic [31:0] LAST_AR         = 32'(BLOCK_COUNT - 1);
  localparam logic [8:0]  MAX_OUT         = 9'(MAX_OUTSTANDING);
  localparam logic [DW-1:0] EXPECTED      = {BEAT_BYTES{FILL_VALUE}};

  typedef enum logic {A_IDLE, A_ISSUE} ar_state_t;

  ar_state_t   ar_state, ar_state_next;
  logic        arvalid_next;
  logic        start_meta, start_sync, start_prev;
  logic        start_pulse, start_accept;
  logic        busy, r_done;
  logic        ar_hs, r_hs, r_last_hs;
  logic [31:0] ar_count;
  logic [31:0] beat_index;
  logic [8:0]  outstanding, outstanding_next;
  logic        p_valid, p_bad, p_resp_err;
  logic [63:0] p_addr;

  assign M_AXI_ARLEN   = 8'(BEATS_PER_BURST - 1);
  assign M_AXI_ARSIZE  = 3'(BEAT_SHIFT);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARID    = 4'd0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;

  assign idle         = ~busy;
  assign start_pulse  = start_sync & ~start_prev;
  assign start_accept = start_pulse & ~busy;
  assign ar_hs        = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs         = M_AXI_RVALID & M_AXI_RREADY;
  assign r_last_hs    = r_hs & M_AXI_RLAST;

  always_comb begin
    outstanding_next = outstanding;
    case ({ar_hs, r_last_hs})
      2'b10:   outstanding_next = outstanding + 9'd1;
      2'b01:   outstanding_next = outstanding - 9'd1;
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      start_meta <= start_async;
      start_sync <= start_meta;
      start_prev <= start_sync;
    end
  end

  // ARVALID is only (re)evaluated when it is low or has just handshaken,
  // so a pending request is never withdrawn.
  always_comb begin
    ar_state_next = ar_state;
    arvalid_next  = M_AXI_ARVALID;
    if (start_accept) begin
      ar_state_next = A_ISSUE;
      arvalid_next  = 1'b1;
    end else begin
      case (ar_state)
        A_IDLE: ar_state_next = A_IDLE;
        A_ISSUE: begin
          if (ar_hs && ar_count == LAST_AR) begin
            ar_state_next = A_IDLE;
            arvalid_next  = 1'b0;
          end else if (ar_hs || !M_AXI_ARVALID) begin
            arvalid_next = (outstanding_next < MAX_OUT);
          end
        end
        default: begin
          ar_state_next = A_IDLE;
          arvalid_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state        <= A_IDLE;
      M_AXI_ARVALID   <= 1'b0;
      M_AXI_ARADDR    <= 64'd0;
      M_AXI_RREADY    <= 1'b0;
      busy            <= 1'b0;
      r_done          <= 1'b0;
      elapsed         <= 64'd0;
      error_count     <= 64'd0;
      resp_err_count  <= 32'd0;
      first_err_valid <= 1'b0;
      first_err_addr  <= 64'd0;
      ar_count        <= 32'd0;
      outstanding     <= 9'd0;
      beat_index      <= 32'd0;
      p_valid         <= 1'b0;
      p_bad           <= 1'b0;
      p_resp_err      <= 1'b0;
      p_addr          <= 64'd0;
    end else begin
      ar_state      <= ar_state_next;
      M_AXI_ARVALID <= arvalid_next;
      if (start_accept) begin
        busy            <= 1'b1;
        r_done          <= 1'b0;
        elapsed         <= 64'd0;
        error_count     <= 64'd0;
        resp_err_count  <= 32'd0;
        first_err_valid <= 1'b0;
        M_AXI_ARADDR    <= BASE_ADDR;
        M_AXI_RREADY    <= 1'b1;
        ar_count        <= 32'd0;
        outstanding     <= 9'd0;
        beat_index      <= 32'd0;
        p_valid         <= 1'b0;
      end else begin
        if (busy)
          elapsed <= elapsed + 64'd1;
        outstanding <= outstanding_next;
        if (ar_hs) begin
          ar_count     <= ar_count + 32'd1;
          M_AXI_ARADDR <= M_AXI_ARADDR + 64'(BLOCK_BYTES);
        end
        // First stage: capture the beat's verdict and its address.
        p_valid <= r_hs;
        if (r_hs) begin
          beat_index <= beat_index + 32'd1;
          p_bad      <= (M_AXI_RDATA != EXPECTED);
          p_resp_err <= |M_AXI_RRESP;
          p_addr     <= BASE_ADDR + (64'(beat_index) << BEAT_SHIFT);
          if (beat_index == LAST_BEAT) begin
            M_AXI_RREADY <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        // Second stage: fold the verdict into the saturating counters.
        if (p_valid) begin
          if (p_bad) begin
            if (error_count != '1)
              error_count <= error_count + 64'd1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_addr  <= p_addr;
            end
          end
          if (p_resp_err && resp_err_count != '1)
            resp_err_count <= resp_err_count + 32'd1;
        end
        // The last beat drains through stage two on this same edge.
        if (r_done) begin
          busy   <= 1'b0;
          r_done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_verify_ram.sv
// Self-checking bench for verify_ram: a randomised AXI read slave plus a
// table of runs whose expected results come from a simple beat-level model.
module tb_verify_ram;

  localparam int          DW    = 512;
  localparam int          BPB   = 4;
  localparam int          NBLK  = 8;
  localparam int          BEATS = BPB * NBLK;
  localparam int          MAXO  = 2;
  localparam int          NVEC  = 9;
  localparam logic [63:0] BASE  = 64'h1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_async;
  logic          idle;
  logic [63:0]   elapsed, error_count, first_err_addr;
  logic          first_err_valid;
  logic [31:0]   resp_err_count;
  logic [63:0]   M_AXI_ARADDR;
  logic [7:0]    M_AXI_ARLEN;
  logic [2:0]    M_AXI_ARSIZE;
  logic [1:0]    M_AXI_ARBURST;
  logic [3:0]    M_AXI_ARID, M_AXI_ARCACHE, M_AXI_ARQOS;
  logic          M_AXI_ARLOCK;
  logic [2:0]    M_AXI_ARPROT;
  logic          M_AXI_ARVALID, M_AXI_ARREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  verify_ram #(
    .DW(DW), .FILL_VALUE(8'hFC), .BASE_ADDR(BASE), .BLOCK_BYTES(256),
    .BLOCK_COUNT(NBLK), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .start_async(start_async), .idle(idle),
    .elapsed(elapsed), .error_count(error_count),
    .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
    .resp_err_count(resp_err_count),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          bad0Beat, bad0Byte;
    logic [7:0]  bad0Val;
    int          bad1Beat, bad1Byte;
    logic [7:0]  bad1Val;
    int          respBeat;
    int          arPct, rPct, rDelay;
    bit          extraStart, expectSlower, checkThrottle;
    logic [63:0] expErr;
    bit          expValid;
    logic [63:0] expAddr;
    logic [63:0] expResp;
  } vec_t;

  vec_t vecs[NVEC];

  int checks = 0;
  int errors = 0;

  // Slave configuration and observation state, shared with the run tasks.
  int          corrBeat[2], corrByte[2];
  logic [7:0]  corrVal[2];
  int          respBeat, arPct, rPct, rDelay;
  logic [63:0] arLog[$];
  logic [63:0] pend[$];
  int          beatsSent, beatInBurst, outstandingModel;
  int          stableViol, throttleViol, arsBeforeLast, cyclesSinceAr;
  bit          seenLast, firstArSeen, rHold, prevStall;
  logic [63:0] prevAddr;
  longint      goodElapsed;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] beatData(input int g);
    logic [DW-1:0] d;
    d = {(DW/8){8'hFC}};
    for (int k = 0; k < 2; k++)
      if (corrBeat[k] == g)
        d[corrByte[k]*8 +: 8] = corrVal[k];
    return d;
  endfunction

  // Reference: a beat is bad if any corruption lands in it; errors are
  // counted per distinct beat and the lowest bad beat gives the address.
  task automatic refModel(input vec_t v, output logic [63:0] e, output bit valid,
                          output logic [63:0] addr, output logic [63:0] resp);
    bit bad[BEATS];
    for (int b = 0; b < BEATS; b++) bad[b] = 1'b0;
    if (v.bad0Beat >= 0) bad[v.bad0Beat] = 1'b1;
    if (v.bad1Beat >= 0) bad[v.bad1Beat] = 1'b1;
    e = 0; valid = 1'b0; addr = 0;
    for (int b = 0; b < BEATS; b++)
      if (bad[b]) begin
        e++;
        if (!valid) begin
          valid = 1'b1;
          addr  = BASE + 64'(b) * 64'(DW/8);
        end
      end
    resp = (v.respBeat >= 0) ? 64'd1 : 64'd0;
  endtask

  // Zero-or-random-wait AXI read slave with protocol monitors.
  task automatic slaveProcess();
    forever begin
      @(posedge clk);
      if (reset) begin
        pend.delete();
        beatInBurst = 0; outstandingModel = 0; firstArSeen = 0;
        rHold = 0; prevStall = 0;
      end else begin
        if (prevStall && (!M_AXI_ARVALID || M_AXI_ARADDR !== prevAddr))
          stableViol++;
        if (M_AXI_ARVALID && outstandingModel >= MAXO)
          throttleViol++;
        prevStall = M_AXI_ARVALID && !M_AXI_ARREADY;
        prevAddr  = M_AXI_ARADDR;
        if (firstArSeen) cyclesSinceAr++;
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          arLog.push_back(M_AXI_ARADDR);
          pend.push_back(M_AXI_ARADDR);
          outstandingModel++;
          firstArSeen = 1;
        end
        rHold = M_AXI_RVALID && !M_AXI_RREADY;
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          beatsSent++;
          beatInBurst++;
          if (M_AXI_RLAST) begin
            outstandingModel--;
            void'(pend.pop_front());
            beatInBurst = 0;
            if (!seenLast) begin
              seenLast = 1;
              arsBeforeLast = arLog.size();
            end
          end
        end
      end
      @(negedge clk);
      M_AXI_ARREADY = ($urandom_range(0, 99) < arPct);
      if (!rHold) begin
        if (pend.size() > 0 && firstArSeen && cyclesSinceAr >= rDelay &&
            $urandom_range(0, 99) < rPct) begin
          M_AXI_RDATA  = beatData(beatsSent);
          M_AXI_RRESP  = (beatsSent == respBeat) ? 2'b10 : 2'b00;
          M_AXI_RLAST  = (beatInBurst == BPB - 1);
          M_AXI_RVALID = 1'b1;
        end else begin
          M_AXI_RDATA  = '0;
          M_AXI_RRESP  = 2'b00;
          M_AXI_RLAST  = 1'b0;
          M_AXI_RVALID = 1'b0;
        end
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic setupRow(input vec_t v);
    corrBeat[0] = v.bad0Beat; corrByte[0] = v.bad0Byte; corrVal[0] = v.bad0Val;
    corrBeat[1] = v.bad1Beat; corrByte[1] = v.bad1Byte; corrVal[1] = v.bad1Val;
    respBeat = v.respBeat; arPct = v.arPct; rPct = v.rPct; rDelay = v.rDelay;
    arLog.delete();
    beatsSent = 0; stableViol = 0; throttleViol = 0; arsBeforeLast = 0;
    cyclesSinceAr = 0; seenLast = 0;
  endtask

  // Pulses start and checks the cleared state of the first busy cycle.
  task automatic startRun(input string name, output bit ok);
    int w;
    @(negedge clk) start_async = 1'b1;
    w = 0;
    while (idle && w < 10) begin
      @(negedge clk);
      w++;
    end
    start_async = 1'b0;
    checkOutput({name, ".started"}, idle, 1'b0);
    ok = !idle;
    if (ok) begin
      checkOutput({name, ".startElapsed"}, elapsed, 64'd0);
      checkOutput({name, ".startArvalid"}, M_AXI_ARVALID, 1'b1);
      checkOutput({name, ".startAraddr"}, M_AXI_ARADDR, BASE);
      checkOutput({name, ".startRready"}, M_AXI_RREADY, 1'b1);
      checkOutput({name, ".startErrCnt"}, error_count, 64'd0);
      checkOutput({name, ".startFirstValid"}, first_err_valid, 1'b0);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output longint measured);
    bit ok;
    int badAddr;
    setupRow(v);
    startRun(v.name, ok);
    measured = 0;
    if (!ok) begin
      doReset();
      return;
    end
    measured = 1;
    forever begin
      @(negedge clk);
      if (v.extraStart && measured == 5)  start_async = 1'b1;
      if (v.extraStart && measured == 12) start_async = 1'b0;
      if (idle) break;
      measured++;
      if (measured > 5000) break;
    end
    start_async = 1'b0;
    checkOutput({v.name, ".finished"}, idle, 1'b1);
    if (!idle) begin
      doReset();
      return;
    end
    checkOutput({v.name, ".errCount"}, error_count, v.expErr);
    checkOutput({v.name, ".firstValid"}, first_err_valid, v.expValid);
    if (v.expValid)
      checkOutput({v.name, ".firstAddr"}, first_err_addr, v.expAddr);
    checkOutput({v.name, ".respCount"}, 64'(resp_err_count), v.expResp);
    checkOutput({v.name, ".elapsed"}, elapsed, 64'(measured));
    checkOutput({v.name, ".arCount"}, arLog.size(), NBLK);
    badAddr = 0;
    for (int k = 0; k < arLog.size(); k++)
      if (arLog[k] !== BASE + 64'(k) * 64'd256) badAddr++;
    checkOutput({v.name, ".arAddrSeq"}, badAddr, 0);
    checkOutput({v.name, ".beats"}, beatsSent, BEATS);
    checkOutput({v.name, ".arStable"}, stableViol, 0);
    checkOutput({v.name, ".throttle"}, throttleViol, 0);
    checkOutput({v.name, ".endRready"}, M_AXI_RREADY, 1'b0);
    checkOutput({v.name, ".endArvalid"}, M_AXI_ARVALID, 1'b0);
    checkOutput({v.name, ".arlen"}, M_AXI_ARLEN, 8'd3);
    checkOutput({v.name, ".arsize"}, M_AXI_ARSIZE, 3'd6);
    if (v.checkThrottle)
      checkOutput({v.name, ".arsBeforeLast"}, arsBeforeLast, MAXO);
    if (v.expectSlower)
      checkOutput({v.name, ".slower"}, measured > goodElapsed, 1'b1);
  endtask

  initial begin
    longint meas;
    bit ok;
    int w, r;
    logic [63:0] e, a, rc;
    bit vld;

    reset = 1'b1; start_async = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    arPct = 100; rPct = 100; rDelay = 0; respBeat = -1;
    corrBeat[0] = -1; corrBeat[1] = -1;
    goodElapsed = 0;
    fork slaveProcess(); join_none

    vecs[0] = '{name:"good", bad0Beat:-1, bad0Byte:0, bad0Val:8'h00, bad1Beat:-1, bad1Byte:0, bad1Val:8'h00,
                respBeat:-1, arPct:100, rPct:100, rDelay:0, extraStart:0, expectSlower:0, checkThrottle:0,
                expErr:0, expValid:0, expAddr:0, expResp:0};
    vecs[1] = vecs[0]; vecs[1].name = "badBytes";
    vecs[1].bad0Beat = 5;  vecs[1].bad0Byte = 0;  vecs[1].bad0Val = 8'h00;
    vecs[1].bad1Beat = 20; vecs[1].bad1Byte = 63; vecs[1].bad1Val = 8'hFD;
    vecs[2] = vecs[0]; vecs[2].name = "throttle"; vecs[2].rDelay = 50; vecs[2].checkThrottle = 1;
    vecs[3] = vecs[0]; vecs[3].name = "rresp"; vecs[3].respBeat = 7;
    vecs[4] = vecs[0]; vecs[4].name = "restart"; vecs[4].extraStart = 1;
    vecs[5] = vecs[0]; vecs[5].name = "backpressure"; vecs[5].arPct = 30; vecs[5].rPct = 50;
    vecs[5].expectSlower = 1;
    for (int i = 6; i < NVEC; i++) begin
      vecs[i] = vecs[0];
      vecs[i].name = $sformatf("random%0d", i);
      r = $urandom_range(0, 3);
      vecs[i].bad0Beat = (r == 0) ? -1 : int'($urandom_range(0, BEATS - 1));
      vecs[i].bad0Byte = $urandom_range(0, 63);
      vecs[i].bad0Val  = 8'hFC ^ 8'($urandom_range(1, 255));
      vecs[i].bad1Beat = int'($urandom_range(0, BEATS - 1));
      vecs[i].bad1Byte = $urandom_range(0, 63);
      vecs[i].bad1Val  = 8'hFC ^ 8'($urandom_range(1, 255));
      r = $urandom_range(0, 1);
      vecs[i].respBeat = (r == 0) ? -1 : int'($urandom_range(0, BEATS - 1));
      vecs[i].arPct = $urandom_range(30, 100);
      vecs[i].rPct  = $urandom_range(40, 100);
    end
    for (int i = 0; i < NVEC; i++) begin
      refModel(vecs[i], e, vld, a, rc);
      vecs[i].expErr = e; vecs[i].expValid = vld; vecs[i].expAddr = a; vecs[i].expResp = rc;
    end

    repeat (3) @(negedge clk);
    checkOutput("reset.idle", idle, 1'b1);
    checkOutput("reset.arvalid", M_AXI_ARVALID, 1'b0);
    checkOutput("reset.rready", M_AXI_RREADY, 1'b0);
    checkOutput("reset.araddr", M_AXI_ARADDR, 64'd0);
    checkOutput("reset.elapsed", elapsed, 64'd0);
    checkOutput("reset.errCount", error_count, 64'd0);
    checkOutput("reset.firstAddr", first_err_addr, 64'd0);
    checkOutput("reset.respCount", 64'(resp_err_count), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], meas);
      if (i == 0) goodElapsed = meas;
      repeat (4) @(negedge clk);
    end

    // Reset in the middle of a run that has already seen a bad beat.
    setupRow(vecs[1]);
    startRun("midReset", ok);
    w = 0;
    while (beatsSent < 10 && w < 500) begin
      @(negedge clk);
      w++;
    end
    checkOutput("midReset.reachedBeat10", beatsSent >= 10, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midReset.idle", idle, 1'b1);
    checkOutput("midReset.arvalid", M_AXI_ARVALID, 1'b0);
    checkOutput("midReset.rready", M_AXI_RREADY, 1'b0);
    checkOutput("midReset.elapsed", elapsed, 64'd0);
    checkOutput("midReset.errCount", error_count, 64'd0);
    checkOutput("midReset.firstValid", first_err_valid, 1'b0);
    checkOutput("midReset.firstAddr", first_err_addr, 64'd0);
    checkOutput("midReset.respCount", 64'(resp_err_count), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(vecs[0], meas);
    checkOutput("afterReset.sameElapsed", 64'(meas), 64'(goodElapsed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/verify_ram.md
Name: verify_ram

Overview:
- Read-back checker that sits directly downstream of the RAM fill stage.
- After a bank has been filled, it reads the whole bank over an AXI4 read master and checks every byte against the fill constant.
- It reports the mismatch count, the address of the first bad beat, the count of bad RRESP beats, and the elapsed cycle count.
- Read-only master; it has no write-channel ports.

Parameters:
- DW, 512: AXI data width in bits; must be a power of 2 and at least 64.
- FILL_VALUE, 8'hFC: expected value of every byte.
- BASE_ADDR, 64'h0: byte address of the first burst.
- BLOCK_BYTES, 4096: bytes per burst. BLOCK_BYTES/(DW/8) must lie in 1..256.
- BLOCK_COUNT, 1024: number of bursts per run, at least 1.
- MAX_OUTSTANDING, 8: maximum AR bursts in flight, in 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start_async  in  1  asynchronous start request; level-synchronised internally by a 2-flop synchroniser, rising edge detected
- idle  out  1  high when no check is in progress
- elapsed  out  64  cycles from start to completion
- error_count  out  64  number of beats with at least one byte != FILL_VALUE
- first_err_valid  out  1  error_count is nonzero
- first_err_addr  out  64  byte address of the first mismatching beat
- resp_err_count  out  32  number of R beats with RRESP != 0
- M_AXI_ARADDR  out  64  burst address
- M_AXI_ARLEN  out  8  constant BLOCK_BYTES/(DW/8)-1
- M_AXI_ARSIZE  out  3  constant $clog2(DW/8)
- M_AXI_ARBURST  out  2  constant 1 (INCR)
- M_AXI_ARID  out  4  constant 0
- M_AXI_ARLOCK / ARCACHE / ARPROT / ARQOS  out  1/4/3/4  constant 0
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  DW
- M_AXI_RRESP  in  2
- M_AXI_RLAST  in  1
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values:
  - idle=1.
  - elapsed, error_count, first_err_addr, resp_err_count all 0.
  - first_err_valid=0, ARVALID=0, RREADY=0, ARADDR=0.
- Start:
  - Start is a one-cycle pulse on the synchronised rising edge of start_async.
  - A start is accepted only while idle=1; a start while busy is ignored.
  - On an accepted start, the next cycle has:
    - idle=0, elapsed=0, error_count=0, resp_err_count=0, first_err_valid=0;
    - ARADDR=BASE_ADDR, ARVALID=1, RREADY=1;
    - internal counters cleared.
- Elapsed: increments by 1 every cycle while idle=0 and freezes when idle returns to 1.
- AR FSM, states A_IDLE and A_ISSUE:
  - Holds ARVALID and ARADDR stable until ARREADY.
  - Each handshake increments ar_count; the next address is ARADDR+BLOCK_BYTES.
  - Issue is throttled by an outstanding counter. Counter +1 on an AR handshake, -1 on an R beat with RLAST. If both happen in the same cycle, the counter is unchanged.
  - ARVALID may assert only when outstanding < MAX_OUTSTANDING. Once asserted, it is not withdrawn before the handshake.
  - After handshake number BLOCK_COUNT, ARVALID=0 and the FSM returns to A_IDLE.
- R path:
  - RREADY=1 throughout the busy period. Every beat is accepted on RVALID with a zero-wait slave.
  - beat_index starts at 0 and increments on every accepted beat.
  - Beat address = BASE_ADDR + beat_index*(DW/8), computed in 64 bits.
  - Compare is byte-wise against {DW/8{FILL_VALUE}}. The comparison may be registered with one pipeline stage; the counters must be final before idle rises.
  - Mismatching beat: error_count += 1 (saturates at all-ones). On the first mismatch only, latch first_err_addr and set first_err_valid=1.
  - RRESP != 0: resp_err_count += 1 (saturating). The data is still compared.
  - RLAST is not used for counting except for the outstanding counter. An RLAST that disagrees with beat position is not flagged.
- Completion:
  - When beat number BLOCK_COUNT*(BLOCK_BYTES/(DW/8)) has been accepted and the compare pipeline has drained: RREADY=0 and idle=1.
  - All result outputs hold until the next accepted start.
- Reset mid-run:
  - All state returns to reset values on the next edge, and in-flight bursts are abandoned.
  - The interconnect must also be reset; this is a system-level requirement.
- Width rules:
  - beat_index is 32 bits, so total beats must fit in 2^32.
  - ar_count is 32 bits.

Test Plan:
1. Good run. Setup: DW=512, BLOCK_BYTES=256 (4 beats), BLOCK_COUNT=8, BASE_ADDR=0x1000, zero-wait slave returning all 0xFC, pulse start. Expect: 8 ARs at 0x1000, 0x1100 … 0x1700, ARLEN=3, ARSIZE=6; 32 beats; error_count=0, first_err_valid=0, idle=1; elapsed matches the measured cycle count.
2. Single bad byte. Setup: as test 1, with byte 0 of beat 5 = 0x00 and byte 63 of beat 20 = 0xFD. Expect: error_count=2, first_err_addr=0x1140, first_err_valid=1.
3. Outstanding throttle. Setup: MAX_OUTSTANDING=2, slave accepts ARs but withholds RVALID for 50 cycles. Expect: exactly 2 AR handshakes, then ARVALID=0 until the first RLAST beat, then the run completes with 8 ARs total.
4. RRESP error. Setup: RRESP=2'b10 on beat 7 with correct data. Expect: resp_err_count=1, error_count=0.
5. Restart and reset. Setup: pulse start while busy, then assert reset at beat 10. Expect: the second start has no effect; one cycle after reset, idle=1, ARVALID=0, RREADY=0, and all counters are 0. A fresh start then completes test 1 again cleanly.
6. Back-pressure. Setup: ARREADY random 30% and RVALID random 50%. Expect: ARADDR/ARVALID stable while stalled, results identical to test 1, and elapsed greater than in test 1.
